// File: rtl/pcm_dac_tx_if.sv
// Sample handshake between the voice mixer (master) and the I2S transmitter (slave).
interface pcm_dac_tx_if #(
  parameter int unsigned SAMPLE_BITS = 18
);
  logic [SAMPLE_BITS-1:0] sample_in;
  logic                   sample_valid;
  logic                   sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/pcm_dac_tx.sv
// Mono 18-bit offset-binary samples to a stereo I2S DAC (BCLK/LRCK/SDATA), one-entry holding reg.
// Optional saturating underrun counter: define PCM_TX_UNDERRUN_CNT_EN.
module pcm_dac_tx #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned SAMPLE_BITS = 18
) (
  input  logic              clk,
  input  logic              rst,
  pcm_dac_tx_if.slave       smp,
  output logic              frame_strobe,
  output logic              underrun,
  output logic [15:0]       underrun_cnt,
  output logic              dac_bclk,
  output logic              dac_lrck,
  output logic              dac_sdata
);

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(2 * SLOT_BITS);
  localparam int unsigned SelW = $clog2(SAMPLE_BITS);

  logic [DivW-1:0]        div_cnt_q, div_cnt_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   bclk_q, bclk_d;
  logic                   lrck_q, lrck_d;
  logic                   sdata_q, sdata_d;
  logic                   strobe_q, strobe_d;
  logic                   underrun_q, underrun_d;
  logic                   hold_full_q, hold_full_d;
  logic [SAMPLE_BITS-1:0] hold_q, hold_d;
  logic [SAMPLE_BITS-1:0] frame_q, frame_d;

  logic                   div_wrap, fall, load, accept, sdata_nxt;
  logic [BitW-1:0]        bit_nxt, pos;
  logic [SelW-1:0]        sel;
  logic [SAMPLE_BITS-1:0] tx_word;

  assign smp.sample_ready = !hold_full_q && !rst;

  always_comb begin
    div_wrap  = (div_cnt_q == DivW'(CLK_DIV - 1));
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;
    fall      = div_wrap && bclk_q;

    bit_nxt   = (bit_cnt_q == BitW'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt_q + 1'b1;
    bit_cnt_d = fall ? bit_nxt : bit_cnt_q;
    load      = fall && (bit_nxt == '0);

    // Offset binary to two's complement; data lags the slot start by one BCLK.
    tx_word   = {~frame_q[SAMPLE_BITS-1], frame_q[SAMPLE_BITS-2:0]};
    pos       = (bit_nxt >= BitW'(SLOT_BITS)) ? bit_nxt - BitW'(SLOT_BITS) : bit_nxt;
    sel       = SelW'(SAMPLE_BITS - 32'(pos));
    sdata_nxt = ((pos != '0) && (pos <= BitW'(SAMPLE_BITS))) ? tx_word[sel] : 1'b0;

    lrck_d     = fall ? (bit_nxt >= BitW'(SLOT_BITS)) : lrck_q;
    sdata_d    = fall ? sdata_nxt : sdata_q;
    strobe_d   = load;
    underrun_d = load && !hold_full_q;

    accept      = smp.sample_valid && smp.sample_ready;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    frame_d     = frame_q;
    if (load && hold_full_q) begin
      frame_d     = hold_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = smp.sample_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      frame_q     <= {1'b1, {(SAMPLE_BITS-1){1'b0}}};
    end else begin
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      frame_q     <= frame_d;
    end
  end

`ifdef PCM_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_d && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = '0;
`endif

  assign frame_strobe = strobe_q;
  assign underrun     = underrun_q;
  assign dac_bclk     = bclk_q;
  assign dac_lrck     = lrck_q;
  assign dac_sdata    = sdata_q;

endmodule

// File: tb/tb_pcm_dac_tx.sv
// Directed bench for pcm_dac_tx: table of samples vs expected serial words, plus corner sequences.
module tb_pcm_dac_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_strobe, underrun, dac_bclk, dac_lrck, dac_sdata;
  logic [15:0] underrun_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_unders = 0;

  always #5 clk = ~clk;

  pcm_dac_tx_if #(.SAMPLE_BITS(18)) smp ();

  pcm_dac_tx #(
    .CLK_DIV    (4),
    .SLOT_BITS  (32),
    .SAMPLE_BITS(18)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .smp         (smp),
    .frame_strobe(frame_strobe),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt),
    .dac_bclk    (dac_bclk),
    .dac_lrck    (dac_lrck),
    .dac_sdata   (dac_sdata)
  );

  typedef struct {
    logic [17:0] sample;
    logic [17:0] exp_word;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef PCM_TX_UNDERRUN_CNT_EN
    return 32'(exp_unders);
`else
    return 32'd0;
`endif
  endfunction

  task automatic wait_strobe(output int n);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (frame_strobe) break;
    end
    chk("strobe_seen", 32'(frame_strobe), 32'd1);
  endtask

  task automatic wait_bclk(input logic lvl);
    int n = 0;
    while (dac_bclk !== lvl && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (dac_bclk !== lvl) chk("bclk_timeout", 32'(dac_bclk), 32'(lvl));
  endtask

  task automatic feed(input logic [17:0] s);
    smp.sample_in    = s;
    smp.sample_valid = 1'b1;
    @(negedge clk);
    smp.sample_valid = 1'b0;
  endtask

  // Record SDATA/LRCK at each BCLK rising edge of one frame, starting just after a strobe.
  task automatic check_frame(input string nm, input logic [17:0] w);
    logic [63:0] bits, lr;
    logic [17:0] lw, rw;
    logic        extra;
    int          lr_bad;
    for (int i = 0; i < 64; i++) begin
      wait_bclk(1'b0);
      wait_bclk(1'b1);
      bits[i] = dac_sdata;
      lr[i]   = dac_lrck;
    end
    extra  = 1'b0;
    lr_bad = 0;
    for (int i = 0; i < 64; i++) begin
      if ((i % 32 == 0) || (i % 32 > 18)) extra = extra | bits[i];
      if (lr[i] !== (i >= 32)) lr_bad++;
    end
    for (int k = 0; k < 18; k++) begin
      lw[17-k] = bits[1+k];
      rw[17-k] = bits[33+k];
    end
    chk({nm, "_left"}, 32'(lw), 32'(w));
    chk({nm, "_right"}, 32'(rw), 32'(w));
    chk({nm, "_pad_zero"}, 32'(extra), 32'd0);
    chk({nm, "_lrck"}, 32'(lr_bad), 32'd0);
  endtask

  initial begin
    int     n;
    logic   sd_bad;
    longint t0;

    vecs[0] = '{sample: 18'h3FFFF, exp_word: 18'h1FFFF};
    vecs[1] = '{sample: 18'h00000, exp_word: 18'h20000};
    vecs[2] = '{sample: 18'h1FFFF, exp_word: 18'h3FFFF};
    vecs[3] = '{sample: 18'h20000, exp_word: 18'h00000};
    vecs[4] = '{sample: 18'h30000, exp_word: 18'h10000};

    smp.sample_in    = '0;
    smp.sample_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 32'(smp.sample_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_bclk", 32'(dac_bclk), 32'd0);
    chk("rst_lrck", 32'(dac_lrck), 32'd0);
    chk("rst_sdata", 32'(dac_sdata), 32'd0);
    chk("rst_strobe", 32'(frame_strobe), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
    chk("rst_ready", 32'(smp.sample_ready), 32'd1);

    wait_bclk(1'b1);
    t0 = $time;
    wait_bclk(1'b0);
    wait_bclk(1'b1);
    chk("bclk_period", 32'(($time - t0) / 10), 32'd8);

    // Idle: two underrun frames of silence.
    wait_strobe(n);
    chk("idle_underrun1", 32'(underrun), 32'd1);
    exp_unders = 1;
    n = 0;
    sd_bad = 1'b0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (dac_sdata) sd_bad = 1'b1;
      if (n == 1) chk("strobe_one_clk", 32'(frame_strobe), 32'd0);
      if (frame_strobe) break;
    end
    chk("frame_period", 32'(n), 32'd512);
    chk("idle_silence", 32'(sd_bad), 32'd0);
    chk("idle_underrun2", 32'(underrun), 32'd1);
    exp_unders = 2;
    chk("idle_ucnt", 32'(underrun_cnt), exp_cnt());

    for (int v = 0; v < 5; v++) begin
      feed(vecs[v].sample);
      wait_strobe(n);
      chk($sformatf("v%0d_no_underrun", v), 32'(underrun), 32'd0);
      check_frame($sformatf("v%0d", v), vecs[v].exp_word);
    end

    // No new sample: last one repeats.
    wait_strobe(n);
    chk("repeat_underrun", 32'(underrun), 32'd1);
    exp_unders = 3;
    check_frame("repeat", 18'h10000);
    chk("repeat_ucnt", 32'(underrun_cnt), exp_cnt());

    // Back-to-back with valid held high.
    smp.sample_in    = 18'h2A5A5;
    smp.sample_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready_drop", 32'(smp.sample_ready), 32'd0);
    smp.sample_in = 18'h15A5A;
    wait_strobe(n);
    chk("b2b_no_underrun1", 32'(underrun), 32'd0);
    chk("b2b_ready_at_strobe", 32'(smp.sample_ready), 32'd1);
    @(negedge clk);
    chk("b2b_ready_after", 32'(smp.sample_ready), 32'd0);
    smp.sample_valid = 1'b0;
    check_frame("b2b_first", 18'h0A5A5);
    wait_strobe(n);
    chk("b2b_no_underrun2", 32'(underrun), 32'd0);
    check_frame("b2b_second", 18'h35A5A);

    // Mid-frame reset with a sample waiting in the holding register.
    wait_strobe(n);
    chk("pre_rst_underrun", 32'(underrun), 32'd1);
    exp_unders = 4;
    chk("pre_rst_ucnt", 32'(underrun_cnt), exp_cnt());
    feed(18'h12345);
    repeat (319) @(negedge clk);
    chk("bit40_lrck", 32'(dac_lrck), 32'd1);
    chk("bit40_hold_full", 32'(smp.sample_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_ready_comb", 32'(smp.sample_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out", 32'({dac_bclk, dac_lrck, dac_sdata, frame_strobe, underrun}), 32'd0);
    chk("mid_rst_ucnt", 32'(underrun_cnt), 32'd0);
    chk("mid_rst_ready", 32'(smp.sample_ready), 32'd1);
    exp_unders = 0;
    wait_strobe(n);
    chk("post_rst_first_strobe", 32'(n), 32'd512);
    chk("post_rst_underrun", 32'(underrun), 32'd1);
    exp_unders = 1;
    check_frame("post_rst_silence", 18'h00000);
    chk("post_rst_ucnt", 32'(underrun_cnt), exp_cnt());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
